// File: rtl/accum_seq_pkg.sv
// ============================================================================
// Module   : accum_seq_pkg
// Brief    : Shared width default, FSM state encoding and datapath mux selects.
// Revision : 1.0
// ============================================================================
`default_nettype none

package accum_seq_pkg;

    localparam int WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;

endpackage : accum_seq_pkg

`default_nettype wire

// File: rtl/accum_seq_accum_unit.sv
// ============================================================================
// Module   : accum_unit
// Brief    : Accumulator register with clear/load, carry-out adder and >= compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module accum_unit #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] addend_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             carry_o,
    output logic             ge_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum_w;

    assign sum_w   = {1'b0, acc_q} + {1'b0, addend_i};
    assign carry_o = sum_w[WIDTH];
    // Compare the truncated sum so the FSM can decide termination in the same cycle it loads.
    assign ge_o    = (sum_w[WIDTH-1:0] >= limit_i);
    assign acc_o   = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (ld_i) begin
            acc_d = sum_w[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : accum_unit

`default_nettype wire

// File: rtl/accum_seq.sv
// ============================================================================
// Module   : accum_seq
// Brief    : Tick-paced repeated-addition sequencer with overflow/zero detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module accum_seq
    import accum_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] steps,
    output logic [1:0]       sel,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             zero_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic             ovf_q, ovf_d;
    logic             zerr_q, zerr_d;
    logic             load_q, load_d;

    logic             unit_clr_w;
    logic             unit_ld_w;
    logic             carry_w;
    logic             ge_w;

    accum_unit #(
        .WIDTH (WIDTH)
    ) u_accum_unit (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .clr_i    (unit_clr_w),
        .ld_i     (unit_ld_w),
        .addend_i (a_q),
        .limit_i  (lim_q),
        .acc_o    (acc),
        .carry_o  (carry_w),
        .ge_o     (ge_w)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        lim_d      = lim_q;
        steps_d    = steps_q;
        ovf_d      = ovf_q;
        zerr_d     = zerr_q;
        load_d     = 1'b0;
        unit_clr_w = 1'b0;
        unit_ld_w  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    lim_d   = limit;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                unit_clr_w = 1'b1;
                steps_d    = '0;
                ovf_d      = 1'b0;
                zerr_d     = 1'b0;
                if (lim_q == '0) begin
                    state_d = ST_DONE;
                end else if (a_q == '0) begin
                    zerr_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (tick) begin
                    if (carry_w) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        unit_ld_w = 1'b1;
                        steps_d   = steps_q + WIDTH'(1);
                        load_d    = 1'b1;
                        if (ge_w) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            lim_q   <= '0;
            steps_q <= '0;
            ovf_q   <= 1'b0;
            zerr_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            lim_q   <= lim_d;
            steps_q <= steps_d;
            ovf_q   <= ovf_d;
            zerr_q  <= zerr_d;
            load_q  <= load_d;
        end
    end

    // load is registered, so it is visible in the cycle the new acc value appears.
    assign load     = load_q;
    assign steps    = steps_q;
    assign ovf      = ovf_q;
    assign zero_err = zerr_q;
    assign sel      = (state_q == ST_ADD) ? SEL_ADD : SEL_HOLD;
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_ADD);
    assign done     = (state_q == ST_DONE);

endmodule : accum_seq

`default_nettype wire

// File: tb/tb_accum_seq.sv
// ============================================================================
// Module   : tb_accum_seq
// Brief    : Directed self-checking bench for accum_seq with hand-computed values.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_accum_seq;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst_n;
    logic             tick;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] steps;
    logic [1:0]       sel;
    logic             load;
    logic             busy;
    logic             done;
    logic             ovf;
    logic             zero_err;

    int n_checks = 0;
    int n_errors = 0;

    accum_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .tick     (tick),
        .start    (start),
        .a        (a),
        .limit    (limit),
        .acc      (acc),
        .steps    (steps),
        .sel      (sel),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .zero_err (zero_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with a one-cycle start; returns 1 ns after the accepting edge.
    task automatic pulse_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] lv);
        a     = av;
        limit = lv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acc"},   32'(acc),   0);
        check({tag, "_steps"}, 32'(steps), 0);
        check({tag, "_sel"},   32'(sel),   0);
        check({tag, "_load"},  32'(load),  0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_ovf"},   32'(ovf),   0);
        check({tag, "_zerr"},  32'(zero_err), 0);
    endtask

    initial begin
        int exp_acc;
        int exp_steps;
        int loads;
        int cyc;

        rst_n = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        a     = '0;
        limit = '0;

        #5;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // a=5, limit=12, tick every cycle
        tick = 1'b1;
        pulse_start(5'd5, 5'd12);
        check("t1_load_busy", 32'(busy), 1);
        check("t1_load_sel",  32'(sel),  0);
        step();
        check("t1_add_sel",   32'(sel),  1);
        check("t1_add_acc0",  32'(acc),  0);
        step();
        check("t1_acc5",      32'(acc),  5);
        check("t1_load1",     32'(load), 1);
        step();
        check("t1_acc10",     32'(acc),  10);
        check("t1_load2",     32'(load), 1);
        step();
        check("t1_acc15",     32'(acc),  15);
        check("t1_load3",     32'(load), 1);
        check("t1_steps",     32'(steps), 3);
        check("t1_done",      32'(done), 1);
        check("t1_ovf",       32'(ovf),  0);
        check("t1_busy",      32'(busy), 0);
        step();
        check("t1_load_off",  32'(load), 0);
        check("t1_done_hold", 32'(done), 1);
        check("t1_sel_done",  32'(sel),  0);
        check("t1_acc_hold",  32'(acc),  15);

        // a=20, limit=31: second addition carries out
        pulse_start(5'd20, 5'd31);
        check("t2_busy",      32'(busy), 1);
        check("t2_done_load", 32'(done), 0);
        step();
        step();
        check("t2_acc20",     32'(acc),  20);
        check("t2_steps1",    32'(steps), 1);
        step();
        check("t2_ovf",       32'(ovf),  1);
        check("t2_acc",       32'(acc),  20);
        check("t2_steps",     32'(steps), 1);
        check("t2_done",      32'(done), 1);
        check("t2_load",      32'(load), 0);

        // limit=0 ends immediately; a=0 flags zero_err
        pulse_start(5'd7, 5'd0);
        check("t3_busy",      32'(busy), 1);
        step();
        check("t3_done",      32'(done), 1);
        check("t3_acc",       32'(acc),  0);
        check("t3_steps",     32'(steps), 0);
        check("t3_zerr",      32'(zero_err), 0);
        check("t3_ovf_clr",   32'(ovf),  0);
        pulse_start(5'd0, 5'd3);
        step();
        check("t3b_done",     32'(done), 1);
        check("t3b_zerr",     32'(zero_err), 1);
        check("t3b_acc",      32'(acc),  0);

        // a=3, limit=9, tick every 4th cycle, stray start mid-ADD
        tick = 1'b0;
        pulse_start(5'd3, 5'd9);
        step();
        check("t4_in_add",    32'(sel),  1);
        exp_acc   = 0;
        exp_steps = 0;
        for (int k = 0; k < 12; k++) begin
            tick  = ((k % 4) == 3);
            start = (k == 1);
            if (k == 1) begin
                a     = 5'd31;
                limit = 5'd1;
            end
            if (tick) begin
                exp_acc   = exp_acc + 3;
                exp_steps = exp_steps + 1;
            end
            step();
            start = 1'b0;
            check($sformatf("t4_acc_k%0d", k), 32'(acc), 32'(exp_acc));
        end
        tick = 1'b0;
        check("t4_steps",     32'(steps), 3);
        check("t4_done",      32'(done), 1);
        check("t4_acc_final", 32'(acc),  9);

        // asynchronous reset mid-ADD with acc=6
        tick = 1'b1;
        pulse_start(5'd3, 5'd30);
        step();
        step();
        step();
        check("t5_acc6",      32'(acc),  6);
        #4;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        #4;
        rst_n = 1'b1;
        pulse_start(5'd1, 5'd31);
        check("t5_first_start", 32'(busy), 1);
        loads = 0;
        cyc   = 0;
        step();
        while (!done && cyc < 40) begin
            step();
            if (load) loads++;
            cyc++;
        end
        check("t5_timeout",   32'(cyc < 40), 1);
        check("t5_steps",     32'(steps), 31);
        check("t5_acc",       32'(acc),  31);
        check("t5_ovf",       32'(ovf),  0);
        check("t5_loads",     32'(loads), 31);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_accum_seq

`default_nettype wire

// File: doc/accum_seq.md
ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand/accumulator width.
REQ-002 SHALL have port CLOCK_50  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick  input  1  one-cycle enable from the clock-divider counter; gates ADD steps.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-006 SHALL have port a  input  WIDTH  addend, sampled on start.
REQ-007 SHALL have port limit  input  WIDTH  target threshold, sampled on start.
REQ-008 SHALL have port acc  output  WIDTH  accumulator value, drives the downstream register/LED path.
REQ-009 SHALL have port steps  output  WIDTH  count of completed additions.
REQ-010 SHALL have port sel  output  2  mux select for the downstream datapath: 01 during ADD, 00 otherwise.
REQ-011 SHALL have port load  output  1  high exactly in cycles where acc is written by an addition.
REQ-012 SHALL have ports busy, done, ovf, zero_err  output  1 each  status flags.

Function
REQ-013 SHALL implement states IDLE, LOAD, ADD, DONE.
REQ-014 IDLE: start=1 SHALL latch a and limit, go to LOAD next cycle; start=0 stays IDLE.
REQ-015 LOAD (one cycle, tick ignored): acc<=0, steps<=0, ovf<=0, zero_err<=0, done<=0.
REQ-016 LOAD exit: limit_lat==0 -> DONE; else a_lat==0 -> DONE with zero_err=1; else -> ADD.
REQ-017 ADD with tick=0: SHALL hold all registers and stay in ADD.
REQ-018 ADD with tick=1: SHALL form WIDTH+1-bit sum = acc + a_lat.
REQ-019 Sum carry-out=1: acc and steps unchanged, ovf<=1, load=0, go DONE.
REQ-020 No carry: acc<=sum[WIDTH-1:0], steps<=steps+1, load=1; if sum>=limit_lat go DONE, else stay ADD.
REQ-021 Comparison SHALL be unsigned, full WIDTH; equality terminates (>=).
REQ-022 steps SHALL never wrap: a_lat>=1 bounds steps to 2^WIDTH-1.
REQ-023 DONE: done=1, acc/steps/flags held; start=1 SHALL latch new operands and go LOAD.
REQ-024 busy SHALL be 1 in LOAD and ADD, 0 in IDLE and DONE.
REQ-025 start in LOAD or ADD SHALL be ignored; operands unchanged.
REQ-026 Outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-027 RESET_N=0 SHALL immediately (asynchronously) force state IDLE and acc, steps, latched operands, ovf, zero_err, done to 0.
REQ-028 Reset outputs: sel=00, load=0, busy=0; applies equally mid-run.
REQ-029 First start after RESET_N release SHALL be accepted on the first rising edge it is seen.

Structure
REQ-030 Shared package SHALL hold WIDTH default, state encoding (IDLE=0, LOAD=1, ADD=2, DONE=3), and SEL_HOLD=00/SEL_ADD=01 constants.
REQ-031 SHALL contain one sub-module, accum_unit: WIDTH-bit acc register with clear, load-enable, adder with carry-out, and >= compare; FSM stays in accum_seq.

Verification
REQ-032 a=5, limit=12, tick every cycle: acc 5,10,15 on successive ADD cycles; DONE with acc=15, steps=3, ovf=0; load high 3 cycles.
REQ-033 a=20, limit=31: acc=20 step 1; step 2 carries (40) -> ovf=1, acc=20, steps=1, done=1.
REQ-034 a=7, limit=0: DONE one cycle after LOAD, acc=0, steps=0, zero_err=0; a=0, limit=3: DONE, zero_err=1.
REQ-035 a=3, limit=9, tick every 4th cycle: acc changes only on tick cycles (3,6,9), steps=3; start pulsed mid-ADD ignored.
REQ-036 Assert RESET_N=0 between clock edges mid-ADD (acc=6): all outputs 0 before next edge; a=1, limit=31 afterward gives steps=31, acc=31, ovf=0.
